// File: rtl/mips8_pkg.sv
// Shared encodings for the mips8 multicycle controller: opcodes, FSM states,
// instruction classes and datapath mux/ALU select codes.
package mips8_pkg;

  localparam logic [3:0] OpRtype = 4'd0;
  localparam logic [3:0] OpAddi  = 4'd1;
  localparam logic [3:0] OpLw    = 4'd2;
  localparam logic [3:0] OpSw    = 4'd3;
  localparam logic [3:0] OpBeq   = 4'd4;
  localparam logic [3:0] OpJ     = 4'd5;

  typedef enum logic [3:0] {
    StIf0    = 4'd0,
    StIf1    = 4'd1,
    StId     = 4'd2,
    StExR    = 4'd3,
    StExI    = 4'd4,
    StExAddr = 4'd5,
    StMemRd  = 4'd6,
    StMemWr  = 4'd7,
    StWbR    = 4'd8,
    StWbI    = 4'd9,
    StWbLd   = 4'd10,
    StBr     = 4'd11,
    StJmp    = 4'd12,
    StTrap   = 4'd13
  } state_e;

  typedef enum logic [2:0] {
    ClsR       = 3'd0,
    ClsAddi    = 3'd1,
    ClsLw      = 3'd2,
    ClsSw      = 3'd3,
    ClsBeq     = 3'd4,
    ClsJ       = 3'd5,
    ClsIllegal = 3'd6
  } instr_cls_e;

  localparam logic [2:0] AluAdd   = 3'b000;
  localparam logic [2:0] AluSub   = 3'b001;
  localparam logic [2:0] AluAnd   = 3'b010;
  localparam logic [2:0] AluOr    = 3'b011;
  localparam logic [2:0] AluSlt   = 3'b100;
  localparam logic [2:0] AluFunct = 3'b101;

  localparam logic [1:0] PcSrcInc    = 2'b00;
  localparam logic [1:0] PcSrcTarget = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  localparam logic [1:0] SrcBRt  = 2'b00;
  localparam logic [1:0] SrcBOne = 2'b01;
  localparam logic [1:0] SrcBImm = 2'b10;

endpackage

// File: rtl/mips8_ctrl_decode.sv
// Combinational opcode to instruction-class decode for the mips8 controller.
module mips8_ctrl_decode
  import mips8_pkg::*;
(
  input  logic [3:0] instr_op_i,
  output logic [2:0] instr_cls_o
);

  always_comb begin
    instr_cls_o = ClsIllegal;
    case (instr_op_i)
      OpRtype: instr_cls_o = ClsR;
      OpAddi:  instr_cls_o = ClsAddi;
      OpLw:    instr_cls_o = ClsLw;
      OpSw:    instr_cls_o = ClsSw;
      OpBeq:   instr_cls_o = ClsBeq;
      OpJ:     instr_cls_o = ClsJ;
      default: instr_cls_o = ClsIllegal;
    endcase
  end

endmodule

// File: rtl/mips8_multicycle_ctrl.sv
// Multicycle control sequencer for the mips8 datapath.
// Define MIPS8_ILLEGAL_TRAP_EN to park illegal opcodes in TRAP instead of treating them as NOPs.
module mips8_multicycle_ctrl
  import mips8_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] instr_op,
  input  logic [2:0] funct,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write_hi,
  output logic       ir_write_lo,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       target_write,
  output logic       trap,
  output logic [3:0] state_o
);

  state_e     state_q, state_d;
  instr_cls_e instr_cls;
  logic [2:0] instr_cls_raw;

  // funct is consumed by the ALU decoder in the datapath, not here.
  logic unused_funct;
  assign unused_funct = ^funct;

  mips8_ctrl_decode u_decode (
    .instr_op_i  (instr_op),
    .instr_cls_o (instr_cls_raw)
  );

  assign instr_cls = instr_cls_e'(instr_cls_raw);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIf0:    if (mem_ready) state_d = StIf1;
      StIf1:    if (mem_ready) state_d = StId;
      StId: begin
        unique case (instr_cls)
          ClsR:        state_d = StExR;
          ClsAddi:     state_d = StExI;
          ClsLw, ClsSw: state_d = StExAddr;
          ClsBeq:      state_d = StBr;
          ClsJ:        state_d = StJmp;
          default: begin
`ifdef MIPS8_ILLEGAL_TRAP_EN
            state_d = StTrap;
`else
            state_d = StIf0;
`endif
          end
        endcase
      end
      StExR:    state_d = StWbR;
      StExI:    state_d = StWbI;
      StExAddr: state_d = (instr_cls == ClsLw) ? StMemRd : StMemWr;
      StMemRd:  if (mem_ready) state_d = StWbLd;
      StMemWr:  if (mem_ready) state_d = StIf0;
      StWbR, StWbI, StWbLd, StBr, StJmp: state_d = StIf0;
      StTrap: begin
`ifdef MIPS8_ILLEGAL_TRAP_EN
        state_d = StTrap;
`else
        state_d = StIf0;
`endif
      end
      default:  state_d = StIf0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIf0;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs decode the current state; reset gates them so an abandoned access drops at once.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    iord         = 1'b0;
    ir_write_hi  = 1'b0;
    ir_write_lo  = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PcSrcInc;
    reg_write    = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = SrcBRt;
    alu_op       = AluAdd;
    target_write = 1'b0;
    trap         = 1'b0;
    state_o      = 4'd0;
    if (!reset) begin
      state_o = state_q;
      unique case (state_q)
        StIf0: begin
          mem_req     = 1'b1;
          ir_write_hi = mem_ready;
          pc_write    = mem_ready;
        end
        StIf1: begin
          mem_req     = 1'b1;
          ir_write_lo = mem_ready;
          pc_write    = mem_ready;
        end
        StId: begin
          alu_src_b    = SrcBImm;
          target_write = 1'b1;
        end
        StExR: begin
          alu_src_a = 1'b1;
          alu_op    = AluFunct;
        end
        StExI, StExAddr: begin
          alu_src_a = 1'b1;
          alu_src_b = SrcBImm;
        end
        StMemRd: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        StMemWr: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          mem_we  = 1'b1;
        end
        StWbR: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        StWbI:    reg_write = 1'b1;
        StWbLd: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        StBr: begin
          alu_src_a = 1'b1;
          alu_op    = AluSub;
          pc_write  = alu_zero;
          pc_src    = PcSrcTarget;
        end
        StJmp: begin
          pc_write = 1'b1;
          pc_src   = PcSrcJump;
        end
        StTrap: begin
`ifdef MIPS8_ILLEGAL_TRAP_EN
          trap = 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips8_multicycle_ctrl.sv
// Directed self-checking bench for mips8_multicycle_ctrl: state traces and strobes per opcode.
module tb_mips8_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] instr_op;
  logic [2:0] funct;
  logic       alu_zero;
  logic       mem_ready;
  logic       mem_req, mem_we, iord, ir_write_hi, ir_write_lo, pc_write;
  logic [1:0] pc_src;
  logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic       target_write, trap;
  logic [3:0] state_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mips8_multicycle_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .instr_op     (instr_op),
    .funct        (funct),
    .alu_zero     (alu_zero),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .iord         (iord),
    .ir_write_hi  (ir_write_hi),
    .ir_write_lo  (ir_write_lo),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .reg_write    (reg_write),
    .reg_dst      (reg_dst),
    .mem_to_reg   (mem_to_reg),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .target_write (target_write),
    .trap         (trap),
    .state_o      (state_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] obs;
    reset = 1'b1; mem_ready = 1'b1; instr_op = 4'd1; funct = 3'd0; alu_zero = 1'b0;
    tick(); tick();
    #2;
    obs = {mem_req, ir_write_hi, pc_write, target_write, trap, |state_o};
    n_checks++;
    if (obs !== 6'b0) begin
      n_fail++; $display("FAIL reset_outputs_zero: got %b want 000000", obs);
    end
    reset = 1'b0;
    #2;
    n_checks++;
    if ({state_o, mem_req, iord, ir_write_hi} !== 7'b0000_101) begin
      n_fail++; $display("FAIL reset_release_if0: got state %0d req %b iord %b irhi %b want 0 1 0 1",
                         state_o, mem_req, iord, ir_write_hi);
    end
    // Stall in IF0: Mealy strobes must drop and state must hold.
    mem_ready = 1'b0;
    #1;
    n_checks++;
    if ({mem_req, ir_write_hi, pc_write} !== 3'b100) begin
      n_fail++; $display("FAIL if0_stall_strobes: got %b want 100", {mem_req, ir_write_hi, pc_write});
    end
    tick(); #2;
    n_checks++;
    if (state_o !== 4'd0) begin
      n_fail++; $display("FAIL if0_stall_hold: got %0d want 0", state_o);
    end
  endtask

  task automatic test_addi();
    instr_op = 4'd1; mem_ready = 1'b1; // ADDI r1,r0,-3
    #2;
    n_checks++;
    if ({ir_write_hi, ir_write_lo, pc_write, pc_src} !== 5'b10100) begin
      n_fail++; $display("FAIL addi_if0: got %b want 10100", {ir_write_hi, ir_write_lo, pc_write, pc_src});
    end
    tick(); #2;
    n_checks++;
    if ({state_o, ir_write_hi, ir_write_lo, pc_write} !== 7'b0001_011) begin
      n_fail++; $display("FAIL addi_if1: got %b want 0001011", {state_o, ir_write_hi, ir_write_lo, pc_write});
    end
    tick(); #2;
    n_checks++;
    if ({state_o, target_write, alu_src_a, alu_src_b, alu_op, mem_req} !== 12'b0010_1_0_10_000_0) begin
      n_fail++; $display("FAIL addi_id: got %b want 001010100000",
                         {state_o, target_write, alu_src_a, alu_src_b, alu_op, mem_req});
    end
    tick(); #2;
    n_checks++;
    if ({state_o, alu_src_a, alu_src_b, alu_op} !== 10'b0100_1_10_000) begin
      n_fail++; $display("FAIL addi_ex_i: got %b want 0100110000", {state_o, alu_src_a, alu_src_b, alu_op});
    end
    tick(); #2;
    n_checks++;
    if ({state_o, reg_write, reg_dst, mem_to_reg} !== 7'b1001_100) begin
      n_fail++; $display("FAIL addi_wb_i: got %b want 1001100", {state_o, reg_write, reg_dst, mem_to_reg});
    end
    tick(); #2;
    n_checks++;
    if (state_o !== 4'd0) begin
      n_fail++; $display("FAIL addi_return_if0: got %0d want 0", state_o);
    end
  endtask

  task automatic test_rtype();
    instr_op = 4'd0; funct = 3'b010; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    #2;
    n_checks++;
    if ({state_o, alu_src_a, alu_src_b, alu_op} !== 10'b0011_1_00_101) begin
      n_fail++; $display("FAIL rtype_ex_r: got %b want 0011100101", {state_o, alu_src_a, alu_src_b, alu_op});
    end
    tick(); #2;
    n_checks++;
    if ({state_o, reg_write, reg_dst, mem_to_reg} !== 7'b1000_110) begin
      n_fail++; $display("FAIL rtype_wb_r: got %b want 1000110", {state_o, reg_write, reg_dst, mem_to_reg});
    end
    tick(); #2;
    n_checks++;
    if (state_o !== 4'd0) begin
      n_fail++; $display("FAIL rtype_return_if0: got %0d want 0", state_o);
    end
  endtask

  task automatic test_lw_wait();
    instr_op = 4'd2; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    #2;
    n_checks++;
    if ({state_o, alu_src_a, alu_src_b, mem_req} !== 8'b0101_1_10_0) begin
      n_fail++; $display("FAIL lw_ex_addr: got %b want 01011100", {state_o, alu_src_a, alu_src_b, mem_req});
    end
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #2;
      n_checks++;
      if ({state_o, mem_req, iord, mem_we, ir_write_hi, ir_write_lo} !== 9'b0110_11000) begin
        n_fail++; $display("FAIL lw_mem_rd_wait%0d: got %b want 011011000", i,
                           {state_o, mem_req, iord, mem_we, ir_write_hi, ir_write_lo});
      end
      tick();
    end
    mem_ready = 1'b1;
    #2;
    n_checks++;
    if ({state_o, mem_req, iord, mem_we} !== 7'b0110_110) begin
      n_fail++; $display("FAIL lw_mem_rd_ready: got %b want 0110110", {state_o, mem_req, iord, mem_we});
    end
    tick(); #2;
    n_checks++;
    if ({state_o, reg_write, mem_to_reg, reg_dst, mem_req} !== 8'b1010_1100) begin
      n_fail++; $display("FAIL lw_wb_ld: got %b want 10101100", {state_o, reg_write, mem_to_reg, reg_dst, mem_req});
    end
    tick(); #2;
    n_checks++;
    if (state_o !== 4'd0) begin
      n_fail++; $display("FAIL lw_return_if0_after_8: got %0d want 0", state_o);
    end
  endtask

  task automatic test_beq();
    instr_op = 4'd4; mem_ready = 1'b1; alu_zero = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    #2;
    n_checks++;
    if ({state_o, pc_write, pc_src, alu_op, alu_src_a, alu_src_b} !== 13'b1011_1_01_001_1_00) begin
      n_fail++; $display("FAIL beq_taken: got %b want 1011101001100",
                         {state_o, pc_write, pc_src, alu_op, alu_src_a, alu_src_b});
    end
    tick(); #2;
    n_checks++;
    if (state_o !== 4'd0) begin
      n_fail++; $display("FAIL beq_taken_return: got %0d want 0", state_o);
    end
    alu_zero = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    #2;
    n_checks++;
    if ({state_o, pc_write} !== 5'b1011_0) begin
      n_fail++; $display("FAIL beq_not_taken: got %b want 10110", {state_o, pc_write});
    end
    tick(); #2;
    n_checks++;
    if (state_o !== 4'd0) begin
      n_fail++; $display("FAIL beq_not_taken_return: got %0d want 0", state_o);
    end
  endtask

  task automatic test_jump();
    instr_op = 4'd5; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    #2;
    n_checks++;
    if ({state_o, pc_write, pc_src, reg_write} !== 8'b1100_1_10_0) begin
      n_fail++; $display("FAIL jmp_state: got %b want 11001100", {state_o, pc_write, pc_src, reg_write});
    end
    tick(); #2;
    n_checks++;
    if (state_o !== 4'd0) begin
      n_fail++; $display("FAIL jmp_return_if0: got %0d want 0", state_o);
    end
  endtask

  task automatic test_reset_mem_wr();
    instr_op = 4'd3; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    mem_ready = 1'b0;
    #2;
    n_checks++;
    if ({state_o, mem_req, iord, mem_we} !== 7'b0111_111) begin
      n_fail++; $display("FAIL sw_mem_wr: got %b want 0111111", {state_o, mem_req, iord, mem_we});
    end
    reset = 1'b1;
    #2;
    n_checks++;
    if ({mem_req, mem_we, iord} !== 3'b000) begin
      n_fail++; $display("FAIL reset_mid_access: got %b want 000", {mem_req, mem_we, iord});
    end
    tick();
    reset = 1'b0;
    #2;
    n_checks++;
    if ({state_o, mem_req} !== 5'b0000_1) begin
      n_fail++; $display("FAIL reset_mid_access_if0: got %b want 00001", {state_o, mem_req});
    end
  endtask

  task automatic test_illegal();
    instr_op = 4'hF; mem_ready = 1'b1;
    for (int i = 0; i < 2; i++) tick();
    #2;
    n_checks++;
    if ({state_o, trap} !== 5'b0010_0) begin
      n_fail++; $display("FAIL illegal_id: got %b want 00100", {state_o, trap});
    end
    tick();
`ifdef MIPS8_ILLEGAL_TRAP_EN
    for (int i = 0; i < 10; i++) begin
      #2;
      n_checks++;
      if ({state_o, trap, mem_req, pc_write, reg_write} !== 8'b1101_1000) begin
        n_fail++; $display("FAIL illegal_trap_hold%0d: got %b want 11011000", i,
                           {state_o, trap, mem_req, pc_write, reg_write});
      end
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
`endif
    #2;
    n_checks++;
    if ({state_o, trap} !== 5'b0000_0) begin
      n_fail++; $display("FAIL illegal_after: got %b want 00000", {state_o, trap});
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_rtype();
    test_lw_wait();
    test_beq();
    test_jump();
    test_reset_mem_wr();
    test_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
